// File: rtl/lpf_pkg.sv
// Shared definitions for the low-pass filter family.
// Sample width, sample type and rounding helper.
package lpf_pkg;

  localparam int IN_WIDTH = 15;

  typedef logic signed [IN_WIDTH:0] sample_t;

  function automatic logic signed [31:0] rnd_shift(
    input logic signed [31:0] v,
    input int unsigned        k
  );
    logic signed [31:0] r;
    r = v;
    if (k != 0) r = v + (32'sd1 <<< (k - 1));
    return r >>> k;
  endfunction

endpackage

// File: rtl/lpf_sync_fifo.sv
// First-word-fall-through synchronous FIFO.
// Wrap-bit pointers, registered occupancy level.
module lpf_sync_fifo #(
  parameter int width      = 16,
  parameter int depth_log2 = 3
) (
  input  logic                I_clk,
  input  logic                I_reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic [width-1:0]    din,
  output logic [width-1:0]    dout,
  output logic                empty,
  output logic                full,
  output logic [depth_log2:0] level
);

  localparam int Depth = 1 << depth_log2;

  logic [width-1:0]    mem_q [Depth];
  logic [depth_log2:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2:0] rd_ptr_q, rd_ptr_d;
  logic [depth_log2:0] level_q, level_d;
  logic                wr_en, rd_en;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[depth_log2] != rd_ptr_q[depth_log2]) &&
            (wr_ptr_q[depth_log2-1:0] == rd_ptr_q[depth_log2-1:0]);
    rd_en = pop & ~empty;
    // a pop frees the slot, so a push into a full FIFO may proceed
    wr_en = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      (wr_en & ~rd_en): level_d = level_q + 1'b1;
      (rd_en & ~wr_en): level_d = level_q - 1'b1;
      default:          level_d = level_q;
    endcase
    dout  = empty ? '0 : mem_q[rd_ptr_q[depth_log2-1:0]];
    level = level_q;
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge I_clk) begin
    if (wr_en) mem_q[wr_ptr_q[depth_log2-1:0]] <= din;
  end

endmodule

// File: rtl/lpf_decim_reader.sv
// Accumulate-and-dump decimator feeding a FWFT FIFO.
// Downstream valid/ready with sticky drop flag.
module lpf_decim_reader
  import lpf_pkg::*;
#(
  parameter int in_width        = IN_WIDTH,
  parameter int dec_log2        = 2,
  parameter int fifo_depth_log2 = 3
) (
  input  logic                       I_clk,
  input  logic                       I_reset_n,
  input  logic signed [in_width:0]   I_data,
  input  logic                       I_valid,
  input  logic                       I_clear,
  output logic signed [in_width:0]   O_data,
  output logic                       O_valid,
  input  logic                       I_ready,
  output logic [fifo_depth_log2:0]   O_level,
  output logic                       O_overflow
);

  localparam int DW = in_width + 1;
  localparam int AW = in_width + dec_log2 + 1;
  localparam int PW = (dec_log2 > 0) ? dec_log2 : 1;
  localparam int N  = 1 << dec_log2;

  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [PW-1:0]        phase_q, phase_d;
  logic                 ovf_q, ovf_d;
  logic signed [DW-1:0] result;
  logic                 push, pop, last;
  logic                 f_empty, f_full;
  logic [DW-1:0]        f_dout;

  always_comb begin
    sum    = acc_q + AW'(I_data);
    result = DW'(rnd_shift(32'(sum), dec_log2));
    last   = (phase_q == PW'(N - 1));
    pop    = I_ready & ~f_empty;
    acc_d   = acc_q;
    phase_d = phase_q;
    ovf_d   = ovf_q;
    push    = 1'b0;
    if (I_clear) begin
      acc_d   = '0;
      phase_d = '0;
      ovf_d   = 1'b0;
    end else if (I_valid) begin
      if (last) begin
        acc_d   = '0;
        phase_d = '0;
        push    = 1'b1;
        if (f_full & ~pop) ovf_d = 1'b1;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      acc_q   <= '0;
      phase_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      phase_q <= phase_d;
      ovf_q   <= ovf_d;
    end
  end

  lpf_sync_fifo #(
    .width      (DW),
    .depth_log2 (fifo_depth_log2)
  ) u_fifo (
    .I_clk     (I_clk),
    .I_reset_n (I_reset_n),
    .push      (push),
    .pop       (pop),
    .din       (result),
    .dout      (f_dout),
    .empty     (f_empty),
    .full      (f_full),
    .level     (O_level)
  );

  assign O_data     = f_dout;
  assign O_valid    = ~f_empty;
  assign O_overflow = ovf_q;

endmodule

// File: tb/tb_lpf_decim_reader.sv
// Directed bench for lpf_decim_reader.
// Vector table plus hand-written FIFO corner sequences.
module tb_lpf_decim_reader;

  logic               I_clk = 1'b0;
  logic               I_reset_n;
  logic signed [15:0] I_data;
  logic               I_valid;
  logic               I_clear;
  logic signed [15:0] O_data;
  logic               O_valid;
  logic               I_ready;
  logic [3:0]         O_level;
  logic               O_overflow;

  int total = 0;
  int bad   = 0;

  lpf_decim_reader dut (
    .I_clk      (I_clk),
    .I_reset_n  (I_reset_n),
    .I_data     (I_data),
    .I_valid    (I_valid),
    .I_clear    (I_clear),
    .O_data     (O_data),
    .O_valid    (O_valid),
    .I_ready    (I_ready),
    .O_level    (O_level),
    .O_overflow (O_overflow)
  );

  always #5 I_clk = ~I_clk;

  typedef struct {
    int s [4];
    int exp;
  } vec_t;

  vec_t vecs [9];

  task automatic step();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int v);
    I_data  = 16'(v);
    I_valid = 1'b1;
    step();
    I_valid = 1'b0;
  endtask

  task automatic block(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  initial begin
    vecs[0] = '{s: '{100, 101, 102, 103}, exp: 102};
    vecs[1] = '{s: '{-1, -2, -2, -2}, exp: -2};
    vecs[2] = '{s: '{1, 1, 1, -1}, exp: 1};
    vecs[3] = '{s: '{32767, 32767, 32767, 32767}, exp: 32767};
    vecs[4] = '{s: '{-32768, -32768, -32768, -32768}, exp: -32768};
    vecs[5] = '{s: '{0, 0, 0, 1}, exp: 0};
    vecs[6] = '{s: '{0, 0, 0, 2}, exp: 1};
    vecs[7] = '{s: '{-3, 0, 0, 0}, exp: -1};
    vecs[8] = '{s: '{-2, 0, 0, 0}, exp: 0};

    I_reset_n = 1'b0;
    I_data    = '0;
    I_valid   = 1'b0;
    I_clear   = 1'b0;
    I_ready   = 1'b1;
    step();
    step();
    chk("rst_valid", int'(O_valid), 0);
    chk("rst_level", int'(O_level), 0);
    chk("rst_ovf", int'(O_overflow), 0);
    chk("rst_data", int'(O_data), 0);
    I_reset_n = 1'b1;
    step();

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 3) chk($sformatf("v%0d_pre_valid", v), int'(O_valid), 0);
        send(vecs[v].s[i]);
      end
      chk($sformatf("v%0d_valid", v), int'(O_valid), 1);
      chk($sformatf("v%0d_data", v), int'(O_data), vecs[v].exp);
      chk($sformatf("v%0d_level", v), int'(O_level), 1);
      step();
      chk($sformatf("v%0d_popped", v), int'(O_valid), 0);
      chk($sformatf("v%0d_level0", v), int'(O_level), 0);
    end

    // sparse valids
    for (int i = 0; i < 4; i++) begin
      chk("sparse_wait", int'(O_valid), 0);
      send(50);
      if (i < 3) begin
        step();
        step();
      end
    end
    chk("sparse_valid", int'(O_valid), 1);
    chk("sparse_data", int'(O_data), 50);
    step();
    chk("sparse_single", int'(O_valid), 0);

    // overflow: nine blocks into eight entries
    I_ready = 1'b0;
    for (int k = 1; k <= 9; k++) block(10 * k);
    chk("ovf_level", int'(O_level), 8);
    chk("ovf_flag", int'(O_overflow), 1);
    chk("ovf_head", int'(O_data), 10);
    I_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_valid%0d", k), int'(O_valid), 1);
      chk($sformatf("drain_data%0d", k), int'(O_data), 10 * k);
      step();
    end
    chk("drain_empty", int'(O_valid), 0);
    chk("drain_level", int'(O_level), 0);
    chk("drain_data0", int'(O_data), 0);
    chk("drain_ovf_sticky", int'(O_overflow), 1);
    I_clear = 1'b1;
    step();
    I_clear = 1'b0;
    chk("clear_ovf", int'(O_overflow), 0);

    // full FIFO, push and pop on the same edge
    I_ready = 1'b0;
    for (int k = 1; k <= 8; k++) block(k);
    chk("fp_full", int'(O_level), 8);
    for (int i = 0; i < 3; i++) send(77);
    I_ready = 1'b1;
    send(77);
    I_ready = 1'b0;
    chk("fp_level", int'(O_level), 8);
    chk("fp_ovf", int'(O_overflow), 0);
    chk("fp_head", int'(O_data), 2);
    I_ready = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      chk($sformatf("fp_data%0d", k), int'(O_data), (k == 9) ? 77 : k);
      step();
    end
    chk("fp_empty", int'(O_valid), 0);

    // clear mid-block, clear beats a simultaneous valid
    send(999);
    send(999);
    I_data  = 16'sd999;
    I_valid = 1'b1;
    I_clear = 1'b1;
    step();
    I_valid = 1'b0;
    I_clear = 1'b0;
    chk("clr_novalid", int'(O_valid), 0);
    block(10);
    chk("clr_valid", int'(O_valid), 1);
    chk("clr_data", int'(O_data), 10);
    step();

    // reset mid-drain and mid-block
    I_ready = 1'b0;
    for (int k = 1; k <= 3; k++) block(k * 5);
    send(500);
    send(500);
    chk("pre_rst_level", int'(O_level), 3);
    I_reset_n = 1'b0;
    step();
    I_reset_n = 1'b1;
    chk("mrst_valid", int'(O_valid), 0);
    chk("mrst_level", int'(O_level), 0);
    chk("mrst_data", int'(O_data), 0);
    block(20);
    chk("post_rst_data", int'(O_data), 20);
    chk("post_rst_level", int'(O_level), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
